sja1000_bus_master: RTL and testbench
=====================================

// Module: sja1000_bus_master
// PURPOSE
//  Hardware bus master for the SJA1000 CAN controller in Intel multiplexed mode (MODE=1).
//  Sits downstream of the system register file: register writes post one command (addr, data, rd/wr).
//  This block generates ALE/CSn/WRn/RDn/AD timing with cycle counters. It returns read data
//  plus a done pulse. Replaces software bit-banging of the SJA1000 pins; adds a timed hardware reset.
// PARAMETERS
//  T_ALE      3     ALE high width, clk cycles (1..255)
//  T_AS       2     address hold after ALE fall, before strobe (1..255)
//  T_STROBE   6     WRn/RDn low width (1..255)
//  T_HOLD     2     strobe high, CSn still low, data held (1..255)
//  T_RECOV    4     CSn high, bus released, before next cmd (1..255)
//  RST_CYCLES 1000  sja1000_rstn low width (1..65535)
//  U_DLY      1     simulation NBA delay
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  async active-low reset
//  cmd_req      in   1  one-cycle command strobe from register file
//  cmd_wr       in   1  1=write, 0=read; sampled with cmd_req
//  cmd_addr     in   8  SJA1000 register address
//  cmd_wdata    in   8  write data
//  rst_req      in   1  one-cycle request for SJA1000 hardware reset
//  cmd_busy     out  1  transaction or reset in progress
//  cmd_done     out  1  one-cycle pulse at transaction end
//  cmd_err      out  1  one-cycle pulse when cmd_req or rst_req is dropped
//  rsp_rdata    out  8  last read data; holds until next read completes
//  sja1000_rstn out  1  chip reset, active low
//  sja1000_csn, sja1000_ale, sja1000_wrn, sja1000_rdn  out 1 each  bus strobes
//  sja1000_ad_o out  8  AD drive value
//  sja1000_ad_oe out 1  AD output enable; top level builds the tri-state
//  sja1000_ad_i in   8  AD pin input
// BEHAVIOUR
//  Reset values: csn=1, ale=0, wrn=1, rdn=1, ad_oe=0, ad_o=0, rstn=1, busy=0, done=0,
//    err=0, rdata=0, FSM=IDLE. Asserting rst_n mid-transaction forces these values immediately.
//  All outputs are registered. busy = (state!=IDLE).
//  FSM: IDLE -> ALE_HI -> ALE_LO -> STROBE -> HOLD -> RECOV -> IDLE; also IDLE -> RESET -> IDLE.
//  Each timed state lasts exactly its parameter N cycles. An 8-bit down-counter loads N-1 on entry.
//  The state advances when the counter reaches 0.
//  Accept rule: in IDLE, cmd_req=1 latches wr/addr/wdata. ALE_HI starts the next cycle.
//    If rst_req and cmd_req arrive together in IDLE, rst_req wins and cmd_err pulses.
//  ALE_HI: ale=1, ad_oe=1, ad_o=addr. ALE_LO: ale=0; addr is still driven.
//  STROBE, write: csn=0, wrn=0, ad_o=wdata, ad_oe=1.
//  STROBE, read: csn=0, rdn=0, ad_oe=0. Register ad_i on the last STROBE cycle into rsp_rdata.
//  HOLD: wrn=rdn=1, csn=0; write data still driven, ad_oe=0 on reads.
//  RECOV: csn=1, ad_oe=0. done=1 in the first IDLE cycle.
//  A cmd_req in that same cycle is accepted (back-to-back).
//  Latency: accept edge to done = T_ALE+T_AS+T_STROBE+T_HOLD+T_RECOV+1 cycles (18 with defaults).
//  Any cmd_req or rst_req arriving while busy is dropped: cmd_err=1 for 1 cycle, no state change.
//  RESET: rstn=0 for RST_CYCLES cycles using a 16-bit counter, then rstn=1 and done pulses. csn stays 1.
//  wrn and rdn are never low together, and no strobe is low while ale=1.
//  ad_oe is never 1 while rdn=0.
// STRUCTURE
//  sja1000_pkg: state encoding localparams, default timing constants.
//  Single module; timing counter and FSM inline. The RESET counter may live in a sub-module sja1000_rst_gen.
// TESTING
//  Write: addr 0x12, data 0xA5, defaults -> ale=1 for 3 cycles with ad_o=0x12;
//    wrn=0 for 6 cycles with ad_o=0xA5; done 18 cycles after accept.
//  Read: addr 0x02, ad_i=0x3C during STROBE -> rdn=0 for 6 cycles, ad_oe=0, rsp_rdata=0x3C at done.
//  Read while ad_i toggles: ad_i=0x11 on early STROBE cycles, 0x77 on the last -> rsp_rdata=0x77.
//  cmd_req during STROBE -> cmd_err=1 for 1 cycle; only one transaction appears on the pins.
//  cmd_req in the done cycle -> second ALE_HI starts the next cycle, with no idle gap beyond RECOV.
//  rst_req -> rstn=0 for exactly 1000 cycles; a cmd_req at cycle 500 -> err.
//    rst_n pulled low mid-STROBE -> pins go to idle values immediately.

Source files
------------

// File: rtl/sja1000_pkg.sv
// Shared types and default timing for the SJA1000 Intel-mode bus master.
package sja1000_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALE_HI,
    ST_ALE_LO,
    ST_STROBE,
    ST_HOLD,
    ST_RECOV,
    ST_RESET
  } state_t;

  localparam int T_ALE_DEF    = 3;
  localparam int T_AS_DEF     = 2;
  localparam int T_STROBE_DEF = 6;
  localparam int T_HOLD_DEF   = 2;
  localparam int T_RECOV_DEF  = 4;
  localparam int RST_CYC_DEF  = 1000;

  function automatic logic [7:0] ld8(input int n);
    return 8'(n - 1);
  endfunction

endpackage

// File: rtl/sja1000_rst_gen.sv
// Chip-reset width counter; flags the final low cycle of the reset pulse.
module sja1000_rst_gen #(
  parameter int RST_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic last
);

  logic [15:0] cnt;
  logic        run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 16'd0;
      run <= 1'b0;
    end else if (start) begin
      cnt <= 16'(RST_CYCLES - 1);
      run <= 1'b1;
    end else if (run) begin
      if (cnt == 16'd0) run <= 1'b0;
      else              cnt <= cnt - 16'd1;
    end
  end

  assign last = run && (cnt == 16'd0);

endmodule

// File: rtl/sja1000_bus_master.sv
// SJA1000 multiplexed-bus master: ALE/CSn/WRn/RDn sequencing and hardware reset.
module sja1000_bus_master
  import sja1000_pkg::*;
#(
  parameter int T_ALE      = T_ALE_DEF,
  parameter int T_AS       = T_AS_DEF,
  parameter int T_STROBE   = T_STROBE_DEF,
  parameter int T_HOLD     = T_HOLD_DEF,
  parameter int T_RECOV    = T_RECOV_DEF,
  parameter int RST_CYCLES = RST_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_req,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  input  logic       rst_req,
  output logic       cmd_busy,
  output logic       cmd_done,
  output logic       cmd_err,
  output logic [7:0] rsp_rdata,
  output logic       sja1000_rstn,
  output logic       sja1000_csn,
  output logic       sja1000_ale,
  output logic       sja1000_wrn,
  output logic       sja1000_rdn,
  output logic [7:0] sja1000_ad_o,
  output logic       sja1000_ad_oe,
  input  logic [7:0] sja1000_ad_i
);

  state_t     state;
  logic [7:0] cnt;
  logic       wr_q;
  logic [7:0] wdata_q;
  logic       rst_start;
  logic       rst_last;

  assign rst_start = (state == ST_IDLE) && rst_req;

  sja1000_rst_gen #(
    .RST_CYCLES(RST_CYCLES)
  ) u_rst_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .start(rst_start),
    .last (rst_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= 8'd0;
      wr_q          <= 1'b0;
      wdata_q       <= 8'd0;
      cmd_busy      <= 1'b0;
      cmd_done      <= 1'b0;
      cmd_err       <= 1'b0;
      rsp_rdata     <= 8'd0;
      sja1000_rstn  <= 1'b1;
      sja1000_csn   <= 1'b1;
      sja1000_ale   <= 1'b0;
      sja1000_wrn   <= 1'b1;
      sja1000_rdn   <= 1'b1;
      sja1000_ad_o  <= 8'd0;
      sja1000_ad_oe <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      if (cnt != 8'd0) cnt <= cnt - 8'd1;
      // Requests that arrive mid-transaction are rejected, never queued.
      if (state != ST_IDLE && (cmd_req || rst_req))
        cmd_err <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (rst_req) begin
            state        <= ST_RESET;
            cmd_busy     <= 1'b1;
            cmd_err      <= cmd_req;
            sja1000_rstn <= 1'b0;
          end else if (cmd_req) begin
            state         <= ST_ALE_HI;
            cmd_busy      <= 1'b1;
            cnt           <= ld8(T_ALE);
            wr_q          <= cmd_wr;
            wdata_q       <= cmd_wdata;
            sja1000_ale   <= 1'b1;
            sja1000_ad_o  <= cmd_addr;
            sja1000_ad_oe <= 1'b1;
          end
        end
        ST_ALE_HI: begin
          if (cnt == 8'd0) begin
            state       <= ST_ALE_LO;
            cnt         <= ld8(T_AS);
            sja1000_ale <= 1'b0;
          end
        end
        ST_ALE_LO: begin
          if (cnt == 8'd0) begin
            state       <= ST_STROBE;
            cnt         <= ld8(T_STROBE);
            sja1000_csn <= 1'b0;
            if (wr_q) begin
              sja1000_wrn   <= 1'b0;
              sja1000_ad_o  <= wdata_q;
              sja1000_ad_oe <= 1'b1;
            end else begin
              sja1000_rdn   <= 1'b0;
              sja1000_ad_oe <= 1'b0;
            end
          end
        end
        ST_STROBE: begin
          if (cnt == 8'd0) begin
            state       <= ST_HOLD;
            cnt         <= ld8(T_HOLD);
            sja1000_wrn <= 1'b1;
            sja1000_rdn <= 1'b1;
            if (!wr_q) rsp_rdata <= sja1000_ad_i;
          end
        end
        ST_HOLD: begin
          if (cnt == 8'd0) begin
            state         <= ST_RECOV;
            cnt           <= ld8(T_RECOV);
            sja1000_csn   <= 1'b1;
            sja1000_ad_oe <= 1'b0;
          end
        end
        ST_RECOV: begin
          if (cnt == 8'd0) begin
            state    <= ST_IDLE;
            cmd_busy <= 1'b0;
            cmd_done <= 1'b1;
          end
        end
        ST_RESET: begin
          if (rst_last) begin
            state        <= ST_IDLE;
            cmd_busy     <= 1'b0;
            cmd_done     <= 1'b1;
            sja1000_rstn <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sja1000_bus_master.sv
// Directed bench for sja1000_bus_master: vector table plus corner sequences.
module tb_sja1000_bus_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_req = 1'b0;
  logic       cmd_wr = 1'b0;
  logic [7:0] cmd_addr = 8'd0;
  logic [7:0] cmd_wdata = 8'd0;
  logic       rst_req = 1'b0;
  logic       cmd_busy, cmd_done, cmd_err;
  logic [7:0] rsp_rdata;
  logic       sja1000_rstn, sja1000_csn, sja1000_ale;
  logic       sja1000_wrn, sja1000_rdn;
  logic [7:0] sja1000_ad_o;
  logic       sja1000_ad_oe;
  logic [7:0] sja1000_ad_i = 8'd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sja1000_bus_master dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_req      (cmd_req),
    .cmd_wr       (cmd_wr),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rst_req      (rst_req),
    .cmd_busy     (cmd_busy),
    .cmd_done     (cmd_done),
    .cmd_err      (cmd_err),
    .rsp_rdata    (rsp_rdata),
    .sja1000_rstn (sja1000_rstn),
    .sja1000_csn  (sja1000_csn),
    .sja1000_ale  (sja1000_ale),
    .sja1000_wrn  (sja1000_wrn),
    .sja1000_rdn  (sja1000_rdn),
    .sja1000_ad_o (sja1000_ad_o),
    .sja1000_ad_oe(sja1000_ad_oe),
    .sja1000_ad_i (sja1000_ad_i)
  );

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] early;
    logic [7:0] last;
    logic [7:0] rdata;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               nm, act, act, exp_v, exp_v);
    end
  endtask

  function automatic int idle_pins();
    return int'({sja1000_csn, sja1000_ale, sja1000_wrn, sja1000_rdn,
                 sja1000_ad_oe, sja1000_rstn, cmd_busy, cmd_done,
                 cmd_err});
  endfunction

  task automatic run_txn(input logic wr, input logic [7:0] a, d,
                         input logic [7:0] early, last,
                         output int lat, output int n_ale,
                         output int n_strb, output int ad_bad,
                         output int inv_bad);
    int edges;
    lat = -1; n_ale = 0; n_strb = 0; ad_bad = 0; inv_bad = 0;
    sja1000_ad_i = early;
    cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_req = 1'b1;
    @(posedge clk); #1;
    cmd_req = 1'b0;
    edges = 1;
    for (int i = 0; i < 40; i++) begin
      if (sja1000_ale) begin
        n_ale++;
        if (sja1000_ad_o !== a || sja1000_ad_oe !== 1'b1) ad_bad++;
      end
      if (!sja1000_wrn) begin
        n_strb++;
        if (sja1000_ad_o !== d || !sja1000_ad_oe || sja1000_csn)
          ad_bad++;
      end
      if (!sja1000_rdn) begin
        n_strb++;
        if (sja1000_ad_oe || sja1000_csn) ad_bad++;
        sja1000_ad_i = (n_strb == 6) ? last : early;
      end
      if (!sja1000_wrn && !sja1000_rdn) inv_bad++;
      if ((!sja1000_wrn || !sja1000_rdn) && sja1000_ale) inv_bad++;
      if (sja1000_ad_oe && !sja1000_rdn) inv_bad++;
      if (cmd_done) begin
        lat = edges;
        break;
      end
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (cmd_done) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n_ale, n_strb, ad_bad, inv_bad;
    int n_err, n_low, n_csn;
    logic prev_ale, hit;

    tbl[0] = '{1'b1, 8'h12, 8'hA5, 8'h00, 8'h00, 8'h00};
    tbl[1] = '{1'b0, 8'h02, 8'h00, 8'h3C, 8'h3C, 8'h3C};
    tbl[2] = '{1'b0, 8'h05, 8'h00, 8'h11, 8'h77, 8'h77};
    tbl[3] = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h77};
    tbl[4] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h80, 8'h80};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pins", idle_pins(), 9'b1_0_1_1_0_1_0_0_0);
    chk("reset_ad_o", int'(sja1000_ad_o), 0);
    chk("reset_rdata", int'(rsp_rdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      run_txn(tbl[v].wr, tbl[v].addr, tbl[v].wdata, tbl[v].early,
              tbl[v].last, lat, n_ale, n_strb, ad_bad, inv_bad);
      chk($sformatf("v%0d_latency", v), lat, 18);
      chk($sformatf("v%0d_ale_cycles", v), n_ale, 3);
      chk($sformatf("v%0d_strobe_cycles", v), n_strb, 6);
      chk($sformatf("v%0d_ad_bus", v), ad_bad, 0);
      chk($sformatf("v%0d_strobe_rules", v), inv_bad, 0);
      chk($sformatf("v%0d_rdata", v), int'(rsp_rdata), int'(tbl[v].rdata));
      chk($sformatf("v%0d_busy_at_done", v), int'(cmd_busy), 0);
      @(posedge clk); #1;
    end

    // cmd_req during STROBE is dropped
    cmd_wr = 1'b1; cmd_addr = 8'h21; cmd_wdata = 8'h5A; cmd_req = 1'b1;
    @(posedge clk); #1;
    cmd_req = 1'b0;
    n_ale = 0; n_err = 0; prev_ale = 1'b0; hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cmd_req = 1'b0;
      if (sja1000_ale && !prev_ale) n_ale++;
      prev_ale = sja1000_ale;
      if (cmd_err) n_err++;
      if (!sja1000_wrn && !hit) begin
        hit = 1'b1;
        cmd_addr = 8'h99;
        cmd_req = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("busy_drop_ale_count", n_ale, 1);
    chk("busy_drop_err_count", n_err, 1);
    chk("busy_drop_idle", int'(cmd_busy), 0);

    // back-to-back: new command in the done cycle
    run_txn(1'b1, 8'h30, 8'h44, 8'h00, 8'h00,
            lat, n_ale, n_strb, ad_bad, inv_bad);
    chk("b2b_first_latency", lat, 18);
    cmd_wr = 1'b0; cmd_addr = 8'h34; cmd_req = 1'b1;
    sja1000_ad_i = 8'h6B;
    @(posedge clk); #1;
    cmd_req = 1'b0;
    chk("b2b_ale_next_cycle", int'({sja1000_ale, sja1000_ad_o}), 9'h134);
    wait_done(lat);
    chk("b2b_second_latency", lat, 17);
    chk("b2b_rdata", int'(rsp_rdata), 8'h6B);
    @(posedge clk); #1;

    // hardware reset with a command dropped half-way
    rst_req = 1'b1;
    @(posedge clk); #1;
    rst_req = 1'b0;
    n_low = 0; n_err = 0; n_csn = 0; hit = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      cmd_req = 1'b0;
      if (cmd_err) n_err++;
      if (!sja1000_csn) n_csn++;
      if (sja1000_rstn) break;
      n_low++;
      if (n_low == 500) cmd_req = 1'b1;
      @(posedge clk); #1;
    end
    chk("rst_low_cycles", n_low, 1000);
    chk("rst_err_count", n_err, 1);
    chk("rst_csn_low", n_csn, 0);
    chk("rst_done_pulse", int'(cmd_done), 1);
    @(posedge clk); #1;

    // rst_req and cmd_req together: reset wins, error flagged
    cmd_wr = 1'b1; cmd_addr = 8'h55; cmd_req = 1'b1; rst_req = 1'b1;
    @(posedge clk); #1;
    cmd_req = 1'b0; rst_req = 1'b0;
    chk("collide_pins",
        int'({cmd_err, sja1000_rstn, sja1000_ale, cmd_busy}), 4'b1001);
    n_low = 1;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk); #1;
      if (sja1000_rstn) break;
      n_low++;
    end
    chk("collide_rst_cycles", n_low, 1000);
    @(posedge clk); #1;

    // async reset in the middle of a read strobe
    cmd_wr = 1'b0; cmd_addr = 8'h0A; cmd_req = 1'b1;
    @(posedge clk); #1;
    cmd_req = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!sja1000_rdn) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("mid_strobe_reached", int'(hit), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pins", idle_pins(), 9'b1_0_1_1_0_1_0_0_0);
    chk("async_rst_rdata", int'(rsp_rdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_idle", idle_pins(), 9'b1_0_1_1_0_1_0_0_0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
